// File: rtl/execute_stage.sv
// Execute stage: ALU, compare/condition codes, branch resolution, address and
// stack-pointer arithmetic, and an iterative shift-add multiplier.
module execute_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] reg_data1_i,
  input  logic [31:0] reg_data2_i,
  input  logic [31:0] sp_data_i,
  input  logic [1:0]  reg_write_i,
  input  logic [1:0]  sp_write_i,
  input  logic [3:0]  bank_i,
  input  logic        halt_i,
  input  logic        exc_i,
  input  logic        stall_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] reg_data1_o,
  output logic [31:0] reg_data2_o,
  output logic [31:0] sp_data_o,
  output logic [1:0]  reg_write_o,
  output logic [1:0]  sp_write_o,
  output logic [3:0]  bank_o,
  output logic        halt_o,
  output logic        exc_o,
  output logic [31:0] result_o,
  output logic        pc_set_o,
  output logic [3:0]  ccr_o,
  output logic        stall_o,
  output logic [1:0]  dbg_mul_state_o
);

  // Handshake: the instruction on the inputs is consumed on a rising edge where
  // stall_o=0; while stall_o=1 the upstream stage holds its inputs and every
  // registered output here holds. stall_o rises combinationally as soon as a
  // multiply is presented, so the multiply stays presented until it retires.

  // Instruction type field encoding, ir[31:28]; types 8-15 are inhibit types.
  localparam logic [3:0] T_ALU  = 4'd0;
  localparam logic [3:0] T_CMP  = 4'd1;
  localparam logic [3:0] T_BR   = 4'd2;
  localparam logic [3:0] T_LD   = 4'd3;
  localparam logic [3:0] T_ST   = 4'd4;
  localparam logic [3:0] T_PUSH = 4'd5;
  localparam logic [3:0] T_POP  = 4'd6;
  localparam logic [3:0] T_MUL  = 4'd7;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [63:0] ir;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sp;
    logic [31:0] result;
    logic [1:0]  rw;
    logic [1:0]  spw;
    logic [3:0]  bank;
    logic [3:0]  ccr;
    logic        halt;
    logic        exc;
    logic        pc_set;
  } out_t;

  out_t       out_q, out_d;
  mul_state_e state_q, state_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [3:0]  typ, op;
  logic [31:0] a, b, sum, diff, imm_ext, br_target;
  logic        mul_req, mul_busy, advance, taken;

  assign typ       = ir_i[31:28];
  assign op        = ir_i[27:24];
  assign a         = reg_data1_i;
  assign b         = ir_i[0] ? ir_i[63:32] : reg_data2_i;
  assign sum       = a + b;
  assign diff      = a - b;
  assign imm_ext   = {{16{ir_i[15]}}, ir_i[15:0]};
  assign br_target = pc_i + {imm_ext[29:0], 2'b00};

  // An excepting instruction never starts a multiply.
  assign mul_req  = (typ == T_MUL) && (op == 4'd0) && !exc_i;
  assign mul_busy = (state_q == MUL_BUSY) || ((state_q == MUL_IDLE) && mul_req);
  assign stall_o  = !rst_i && (stall_i || mul_busy);
  assign advance  = !stall_o;

  always_comb begin
    taken = 1'b0;
    case (op)
      4'd0:    taken = 1'b1;
      4'd1:    taken = out_q.ccr[0];
      4'd2:    taken = !out_q.ccr[0];
      4'd3:    taken = out_q.ccr[3];
      4'd4:    taken = !out_q.ccr[3];
      4'd5:    taken = out_q.ccr[1];
      4'd6:    taken = !out_q.ccr[1];
      4'd7:    taken = out_q.ccr[2];
      4'd8:    taken = !(out_q.ccr[1] ^ out_q.ccr[2]);
      4'd9:    taken = out_q.ccr[1] ^ out_q.ccr[2];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    out_d        = '0;
    out_d.ir     = ir_i;
    out_d.pc     = pc_i;
    out_d.rd1    = a;
    out_d.rd2    = reg_data2_i;
    out_d.sp     = sp_data_i;
    out_d.result = sum;
    out_d.rw     = reg_write_i;
    out_d.spw    = sp_write_i;
    out_d.bank   = bank_i;
    out_d.ccr    = out_q.ccr;
    out_d.halt   = halt_i;
    out_d.exc    = exc_i;
    out_d.pc_set = 1'b0;
    if (exc_i) begin
      out_d.result = sp_data_i - 32'd4;
      out_d.sp     = sp_data_i - 32'd4;
      out_d.spw    = 2'd3;
    end else begin
      case (typ)
        T_ALU: begin
          case (op)
            4'd0:    out_d.result = sum;
            4'd1:    out_d.result = diff;
            4'd2:    out_d.result = a & b;
            4'd3:    out_d.result = a | b;
            4'd4:    out_d.result = a ^ b;
            4'd5:    out_d.result = a << b[4:0];
            4'd6:    out_d.result = a >> b[4:0];
            4'd7:    out_d.result = $unsigned($signed(a) >>> b[4:0]);
            default: begin
              out_d.result = '0;
              out_d.rw     = 2'd0;
            end
          endcase
        end
        T_CMP: begin
          out_d.result = diff;
          out_d.rw     = 2'd0;
          out_d.ccr    = {a < b, (a[31] ^ b[31]) & (diff[31] ^ a[31]),
                          diff[31], diff == 32'd0};
        end
        T_BR: begin
          out_d.result = br_target;
          out_d.pc_set = taken;
        end
        T_LD, T_ST: out_d.result = sum;
        T_PUSH: begin
          out_d.sp     = sp_data_i - 32'd4;
          out_d.spw    = 2'd3;
          out_d.result = (op == 4'd0) ? a : sum;
          out_d.pc_set = (op != 4'd0);
        end
        T_POP: begin
          out_d.sp  = sp_data_i + 32'd4;
          out_d.spw = 2'd3;
          out_d.rd1 = sp_data_i;
        end
        T_MUL: begin
          if (op == 4'd0) begin
            out_d.result = acc_q;
          end else begin
            out_d.result = '0;
            out_d.rw     = 2'd0;
          end
        end
        default: out_d.result = sum;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (mul_req && !stall_i) begin
          state_d = MUL_BUSY;
          ma_d    = a;
          mb_d    = b;
          acc_d   = '0;
          cnt_d   = 5'd31;
        end
      end
      MUL_BUSY: begin
        acc_d = acc_q + (mb_q[0] ? ma_q : 32'd0);
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (!stall_i) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      state_q <= MUL_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (advance) out_q <= out_d;
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir_o            = out_q.ir;
  assign pc_o            = out_q.pc;
  assign reg_data1_o     = out_q.rd1;
  assign reg_data2_o     = out_q.rd2;
  assign sp_data_o       = out_q.sp;
  assign reg_write_o     = out_q.rw;
  assign sp_write_o      = out_q.spw;
  assign bank_o          = out_q.bank;
  assign halt_o          = out_q.halt;
  assign exc_o           = out_q.exc;
  assign result_o        = out_q.result;
  assign pc_set_o        = out_q.pc_set;
  assign ccr_o           = out_q.ccr;
  assign dbg_mul_state_o = state_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage, checked against a
// behavioural model of the instruction set held in the bench.
module tb_execute_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i, reg_data1_i, reg_data2_i, sp_data_i;
  logic [1:0]  reg_write_i, sp_write_i;
  logic [3:0]  bank_i;
  logic        halt_i, exc_i, stall_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o, reg_data1_o, reg_data2_o, sp_data_o, result_o;
  logic [1:0]  reg_write_o, sp_write_o, dbg_mul_state_o;
  logic [3:0]  bank_o, ccr_o;
  logic        halt_o, exc_o, pc_set_o, stall_o;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [63:0] ir;
    logic [31:0] pc, a, b, sp;
    logic [1:0]  rw, spw;
    logic [3:0]  bank;
    logic        halt, exc;
  } in_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] ir;
    logic [31:0] rd1, rd2, sp;
    logic [1:0]  rw, spw;
    logic [3:0]  bank;
    logic        halt, exc;
    logic [31:0] result;
    logic        pc_set;
    logic [3:0]  ccr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_e;
  logic [3:0] ccr_m;
  int         checks = 0;
  int         errors = 0;

  execute_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i),
    .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i), .sp_data_i(sp_data_i),
    .reg_write_i(reg_write_i), .sp_write_i(sp_write_i), .bank_i(bank_i),
    .halt_i(halt_i), .exc_i(exc_i), .stall_i(stall_i),
    .ir_o(ir_o), .pc_o(pc_o), .reg_data1_o(reg_data1_o), .reg_data2_o(reg_data2_o),
    .sp_data_o(sp_data_o), .reg_write_o(reg_write_o), .sp_write_o(sp_write_o),
    .bank_o(bank_o), .halt_o(halt_o), .exc_o(exc_o), .result_o(result_o),
    .pc_set_o(pc_set_o), .ccr_o(ccr_o), .stall_o(stall_o),
    .dbg_mul_state_o(dbg_mul_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Reference model: the architectural effect of one instruction.
  function automatic exp_t model(input in_t x, input logic [3:0] ccr);
    exp_t        e;
    logic [31:0] bb, d;
    logic [3:0]  typ, op;
    longint      sd;
    logic        c, v, n, z, tk;
    typ = x.ir[31:28];
    op  = x.ir[27:24];
    bb  = x.ir[0] ? x.ir[63:32] : x.b;
    e.pc = x.pc; e.ir = x.ir; e.rd1 = x.a; e.rd2 = x.b; e.sp = x.sp;
    e.rw = x.rw; e.spw = x.spw; e.bank = x.bank; e.halt = x.halt; e.exc = x.exc;
    e.result = x.a + bb; e.pc_set = 1'b0; e.ccr = ccr;
    if (x.exc) begin
      e.result = x.sp - 4; e.sp = x.sp - 4; e.spw = 2'd3;
      return e;
    end
    case (typ)
      4'd0: begin
        case (op)
          4'd0: e.result = x.a + bb;
          4'd1: e.result = x.a - bb;
          4'd2: e.result = x.a & bb;
          4'd3: e.result = x.a | bb;
          4'd4: e.result = x.a ^ bb;
          4'd5: e.result = x.a << bb[4:0];
          4'd6: e.result = x.a >> bb[4:0];
          4'd7: e.result = int'(x.a) >>> bb[4:0];
          default: begin e.result = 0; e.rw = 0; end
        endcase
      end
      4'd1: begin
        d  = x.a - bb;
        sd = longint'($signed(x.a)) - longint'($signed(bb));
        z  = (x.a == bb);
        n  = d[31];
        c  = (x.a < bb);
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.result = d; e.rw = 0; e.ccr = {c, v, n, z};
      end
      4'd2: begin
        case (op)
          4'd0: tk = 1;
          4'd1: tk = ccr[0];
          4'd2: tk = !ccr[0];
          4'd3: tk = ccr[3];
          4'd4: tk = !ccr[3];
          4'd5: tk = ccr[1];
          4'd6: tk = !ccr[1];
          4'd7: tk = ccr[2];
          4'd8: tk = (ccr[1] == ccr[2]);
          4'd9: tk = (ccr[1] != ccr[2]);
          default: tk = 0;
        endcase
        e.result = x.pc + 32'(int'($signed(x.ir[15:0])) * 4);
        e.pc_set = tk;
      end
      4'd5: begin
        e.sp = x.sp - 4; e.spw = 2'd3;
        e.result = (op == 0) ? x.a : x.a + bb;
        e.pc_set = (op != 0);
      end
      4'd6: begin
        e.sp = x.sp + 4; e.spw = 2'd3; e.rd1 = x.sp;
      end
      4'd7: begin
        if (op == 0) e.result = 32'(longint'(x.a) * longint'(bb));
        else begin e.result = 0; e.rw = 0; end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic in_t mk(input logic [31:0] ir_lo, input logic [31:0] imm,
                             input logic [31:0] pc, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] sp,
                             input logic exc);
    in_t x;
    x.ir = {imm, ir_lo}; x.pc = pc; x.a = a; x.b = b; x.sp = sp; x.exc = exc;
    x.rw = 2'($urandom); x.spw = 2'($urandom); x.bank = 4'($urandom);
    x.halt = 1'($urandom);
    return x;
  endfunction

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_result"}, result_o, e.result);
    chk({tag, "_pc_set"}, pc_set_o, e.pc_set);
    chk({tag, "_ccr"}, ccr_o, e.ccr);
    chk({tag, "_rw"}, reg_write_o, e.rw);
    chk({tag, "_spw"}, sp_write_o, e.spw);
    chk({tag, "_sp"}, sp_data_o, e.sp);
    chk({tag, "_rd1"}, reg_data1_o, e.rd1);
    chk({tag, "_exc"}, exc_o, e.exc);
    chk({tag, "_pass"}, {pc_o, ir_o, reg_data2_o, bank_o, halt_o},
        {e.pc, e.ir, e.rd2, e.bank, e.halt});
    ccr_m  = e.ccr;
    last_e = e;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_held"}, {result_o, pc_set_o, ccr_o, sp_data_o, pc_o, ir_o},
        {last_e.result, last_e.pc_set, last_e.ccr, last_e.sp, last_e.pc, last_e.ir});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_outs"}, {ir_o, pc_o, reg_data1_o, reg_data2_o, sp_data_o, reg_write_o,
        sp_write_o, bank_o, halt_o, exc_o, result_o, pc_set_o, ccr_o, stall_o}, '0);
    chk({tag, "_state"}, dbg_mul_state_o, ST_IDLE);
  endtask

  // Drivers
  task automatic drive(input in_t x);
    ir_i = x.ir; pc_i = x.pc; reg_data1_i = x.a; reg_data2_i = x.b;
    sp_data_i = x.sp; reg_write_i = x.rw; sp_write_i = x.spw;
    bank_i = x.bank; halt_i = x.halt; exc_i = x.exc;
  endtask

  task automatic step(input in_t x, input string tag);
    drive(x);
    stall_i = 1'b0;
    exp_q.push_back(model(x, ccr_m));
    @(posedge clk_i); #1;
    check_out(tag);
    chk({tag, "_stall"}, stall_o, 1'b0);
  endtask

  task automatic do_mul(input in_t x, input int hold, input string tag);
    int n;
    drive(x);
    stall_i = 1'b0;
    #1;
    chk({tag, "_issue_stall"}, stall_o, 1'b1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_i); #1;
      if (!stall_o) break;
      n++;
      if (n == 10) check_held({tag, "_busy"});
    end
    chk({tag, "_busy_cycles"}, n, 32);
    chk({tag, "_done_state"}, dbg_mul_state_o, ST_DONE);
    stall_i = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_i); #1;
      check_held({tag, "_done_hold"});
      chk({tag, "_done_hold_state"}, dbg_mul_state_o, ST_DONE);
    end
    stall_i = 1'b0;
    exp_q.push_back(model(x, ccr_m));
    @(posedge clk_i); #1;
    check_out(tag);
    chk({tag, "_idle_after"}, dbg_mul_state_o, ST_IDLE);
  endtask

  initial begin
    in_t x;
    logic [3:0] typ, op;
    rst_i = 1'b1;
    stall_i = 1'b0;
    drive('0);
    ccr_m = '0;
    last_e = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("reset");
    rst_i = 1'b0;

    // Add with immediate wrap-around; one-cycle latency.
    x = mk(32'h0000_0001, 32'h1, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'h500, 1'b0);
    x.rw = 2'd1;
    step(x, "add_wrap");
    chk("add_wrap_const", {result_o, reg_write_o}, {32'h0, 2'd1});

    // Compare 3 vs 5, then branch-on-carry backwards.
    step(mk(32'h1000_0000, 32'h0, 32'h44, 32'd3, 32'd5, 32'h500, 1'b0), "cmp_3_5");
    chk("cmp_3_5_const", ccr_o, 4'b1010);
    step(mk(32'h2300_FFFE, 32'h0, 32'h100, 32'h7, 32'h9, 32'h500, 1'b0), "br_c");
    chk("br_c_const", {pc_set_o, result_o}, {1'b1, 32'hF8});
    step(mk(32'h0000_0000, 32'h0, 32'h104, 32'h1, 32'h2, 32'h500, 1'b0), "after_br");

    // Push then pop around SP 0x1000.
    step(mk(32'h5000_0000, 32'h0, 32'h108, 32'hABCD, 32'h1, 32'h1000, 1'b0), "push");
    chk("push_const", {sp_data_o, sp_write_o, result_o}, {32'hFFC, 2'd3, 32'hABCD});
    step(mk(32'h6000_0000, 32'h0, 32'h10C, 32'h5, 32'h6, 32'h1000, 1'b0), "pop");
    chk("pop_const", {sp_data_o, reg_data1_o}, {32'h1004, 32'h1000});
    step(mk(32'h5100_0000, 32'h0, 32'h110, 32'h200, 32'h10, 32'h1000, 1'b0), "call");
    step(mk(32'h0000_0000, 32'h0, 32'h114, 32'h1, 32'h1, 32'h1000, 1'b0), "after_call");

    // Exception on a compare: ccr must not move.
    step(mk(32'h1000_0000, 32'h0, 32'h118, 32'd9, 32'd9, 32'h2000, 1'b1), "exc");
    chk("exc_const", {exc_o, result_o, ccr_o}, {1'b1, 32'h1FFC, 4'b1010});

    // Downstream stall holds every output.
    x = mk(32'h1000_0000, 32'h0, 32'h11C, 32'd7, 32'd7, 32'h300, 1'b0);
    drive(x);
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      check_held("stall");
      chk("stall_o_follow", stall_o, 1'b1);
    end
    step(x, "stall_release");

    // Multiplies: directed with stall held in DONE, then random.
    do_mul(mk(32'h7000_0000, 32'h0, 32'h120, 32'h12345, 32'h10, 32'h300, 1'b0), 3, "mul_dir");
    chk("mul_dir_const", result_o, 32'h123450);
    do_mul(mk(32'h7000_0000, 32'h0, 32'h124, $urandom, $urandom, 32'h300, 1'b0), 0, "mul_rnd");

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      typ = 4'($urandom_range(0, 9));
      op  = 4'($urandom_range(0, 15));
      if (typ == 4'd7 && op == 4'd0) op = 4'd1;
      x = mk({typ, op, 24'($urandom)}, $urandom, $urandom, $urandom, $urandom,
             $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) x.b = x.a;
      step(x, "rnd");
    end

    // Reset at multiply busy cycle 10 aborts it.
    drive(mk(32'h7000_0000, 32'h0, 32'h200, 32'h55, 32'h66, 32'h300, 1'b0));
    stall_i = 1'b0;
    @(posedge clk_i);
    repeat (9) @(posedge clk_i);
    #1;
    chk("pre_abort_state", dbg_mul_state_o, ST_BUSY);
    rst_i = 1'b1;
    #1;
    check_reset("mul_abort");
    x = mk(32'h0000_0000, 32'h0, 32'h204, 32'd10, 32'd20, 32'h300, 1'b0);
    drive(x);
    @(posedge clk_i); #1;
    check_reset("mul_abort_hold");
    rst_i = 1'b0;
    ccr_m = '0;
    exp_q.delete();
    step(x, "add_after_reset");
    chk("add_after_reset_const", result_o, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
